// File: rtl/gray_sync_decoder.sv
// Receive-side Gray pointer synchronizer/decoder for the async FIFO: sync chain, Gray->binary
// decode, registered pointer distance, change pulse. GRAY_SYNC_DECODER_CHECK_EN adds the sticky GrayErr.
module gray_sync_decoder #(
   parameter int ADDR_WIDTH  = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_WIDTH:0] GrayIn,
   input  logic [ADDR_WIDTH:0] LocalBin,
   input  logic                ErrClr,
   output logic [ADDR_WIDTH:0] BinaryVal,
   output logic [ADDR_WIDTH:0] PtrDiff,
   output logic                Changed,
   output logic                GrayErr
);

   localparam int PW = ADDR_WIDTH + 1;

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic int popcount(input logic [PW-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < PW; i++) begin
         n = n + int'(v[i]);
      end
      return n;
   endfunction

   logic [PW-1:0] sync_q [SYNC_STAGES];
   logic [PW-1:0] sync_d [SYNC_STAGES];
   logic [PW-1:0] gray_last;
   logic [PW-1:0] prev_gray_p1_q, prev_gray_p1_d;
   logic [PW-1:0] bin_p1_q, bin_p1_d;
   logic          changed_p1_q, changed_p1_d;
   logic [PW-1:0] ptr_diff_p2_q, ptr_diff_p2_d;

   always_comb begin
      sync_d[0] = GrayIn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      gray_last = sync_q[SYNC_STAGES-1];
      // decode stage
      prev_gray_p1_d = gray_last;
      bin_p1_d       = gray2bin(gray_last);
      changed_p1_d   = (gray_last != prev_gray_p1_q);
      // distance stage; modular subtraction handles the wrap bit
      ptr_diff_p2_d  = LocalBin - bin_p1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         prev_gray_p1_q <= '0;
         bin_p1_q       <= '0;
         changed_p1_q   <= 1'b0;
         ptr_diff_p2_q  <= '0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         prev_gray_p1_q <= prev_gray_p1_d;
         bin_p1_q       <= bin_p1_d;
         changed_p1_q   <= changed_p1_d;
         ptr_diff_p2_q  <= ptr_diff_p2_d;
      end
   end

`ifdef GRAY_SYNC_DECODER_CHECK_EN
   logic err_q, err_d;
   logic violation;

   // a set in the same cycle as ErrClr takes priority
   always_comb begin
      violation = (popcount(gray_last ^ prev_gray_p1_q) > 1);
      err_d     = err_q;
      if (violation) begin
         err_d = 1'b1;
      end else if (ErrClr) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign GrayErr = err_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = ErrClr;
   assign GrayErr        = 1'b0;
`endif

   assign BinaryVal = bin_p1_q;
   assign PtrDiff   = ptr_diff_p2_q;
   assign Changed   = changed_p1_q;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Self-checking bench for gray_sync_decoder: directed scenarios plus randomized Gray walks
// checked against a cycle-history reference model.
module tb_gray_sync_decoder;

   localparam int AW = 5;
   localparam int S  = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW:0]   GrayIn = '0;
   logic [AW:0]   LocalBin = '0;
   logic          ErrClr = 1'b0;
   logic [AW:0]   BinaryVal;
   logic [AW:0]   PtrDiff;
   logic          Changed;
   logic          GrayErr;

   int n_assert = 0;
   int n_fail   = 0;

   logic [AW:0] hist[$];
   logic        exp_err;

   gray_sync_decoder #(.ADDR_WIDTH(AW), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst_n(rst_n), .GrayIn(GrayIn), .LocalBin(LocalBin), .ErrClr(ErrClr),
      .BinaryVal(BinaryVal), .PtrDiff(PtrDiff), .Changed(Changed), .GrayErr(GrayErr)
   );

   always #5 clk = ~clk;

   function automatic logic [AW:0] to_gray(input logic [AW:0] b);
      return b ^ (b >> 1);
   endfunction

   // inverse found by search over all pointer values
   function automatic logic [AW:0] from_gray(input logic [AW:0] g);
      for (int v = 0; v < (1 << (AW + 1)); v++) begin
         if (to_gray(v[AW:0]) == g) return v[AW:0];
      end
      return '0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < S + 2; i++) hist.push_back('0);
      exp_err = 1'b0;
   endtask

   // drive at negedge, clock one edge, check all outputs 1 time unit later
   task automatic step(input logic [AW:0] g, input logic [AW:0] l, input logic c);
      logic [AW:0] gc, gp, ediff;
      int n;
      GrayIn = g; LocalBin = l; ErrClr = c;
      @(posedge clk);
      hist.push_back(g);
      n  = hist.size();
      gc = hist[n-1-S];
      gp = hist[n-2-S];
      ediff = l - from_gray(gp);
`ifdef GRAY_SYNC_DECODER_CHECK_EN
      if ($countones(gc ^ gp) > 1) exp_err = 1'b1;
      else if (c) exp_err = 1'b0;
`endif
      #1;
      check("BinaryVal", 32'(BinaryVal), 32'(from_gray(gc)));
      check("Changed",   32'(Changed),   32'(gc != gp));
      check("PtrDiff",   32'(PtrDiff),   32'(ediff));
      check("GrayErr",   32'(GrayErr),   32'(exp_err));
      @(negedge clk);
   endtask

   initial begin
      logic [AW:0] rb, g, lb;
      model_reset();
      #2;
      check("por_bin", 32'(BinaryVal), 0);
      check("por_diff", 32'(PtrDiff), 0);
      check("por_chg", 32'(Changed), 0);
      check("por_err", 32'(GrayErr), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // decode and latency
      step(6'd0, 6'd9, 1'b0);
      step(6'd0, 6'd9, 1'b0);
      step(6'b000111, 6'd9, 1'b0);
      step(6'b000111, 6'd9, 1'b0);
      step(6'b000111, 6'd9, 1'b0);
      check("dec_bin5", 32'(BinaryVal), 5);
      check("dec_chg", 32'(Changed), 1);
      step(6'b000111, 6'd9, 1'b0);
      check("dec_diff4", 32'(PtrDiff), 4);
      check("dec_chg_drop", 32'(Changed), 0);
      step(6'b000111, 6'd9, 1'b1);

      // asynchronous reset mid-cycle
      GrayIn = 6'b100000;
      #2 rst_n = 1'b0;
      #1;
      check("rst_bin", 32'(BinaryVal), 0);
      check("rst_diff", 32'(PtrDiff), 0);
      check("rst_chg", 32'(Changed), 0);
      check("rst_err", 32'(GrayErr), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(6'b100000, 6'd0, 1'b0);
      step(6'b100000, 6'd0, 1'b0);
      step(6'b100000, 6'd0, 1'b0);
      check("rst_bin63", 32'(BinaryVal), 63);

      // wrap through 63 -> 0
      for (int b = 60; b <= 65; b++) begin
         rb = 6'(b);
         step(to_gray(rb), 6'd3, 1'b0);
      end
      for (int i = 0; i < 4; i++) step(6'd0, 6'd3, 1'b0);
      check("wrap_bin0", 32'(BinaryVal), 0);
      check("wrap_noerr", 32'(GrayErr), 0);

      // integrity: two-bit jump, hold, clear, then set coinciding with clear
      step(6'b000011, 6'd0, 1'b0);
      step(6'b000011, 6'd0, 1'b0);
      step(6'b000011, 6'd0, 1'b0);
      check("int_bin2", 32'(BinaryVal), 2);
`ifdef GRAY_SYNC_DECODER_CHECK_EN
      check("int_err_set", 32'(GrayErr), 1);
`else
      check("int_err_off", 32'(GrayErr), 0);
`endif
      step(6'b000011, 6'd0, 1'b0);
      step(6'b000011, 6'd0, 1'b1);
      check("int_err_clr", 32'(GrayErr), 0);
      step(6'b000000, 6'd0, 1'b0);
      step(6'b000000, 6'd0, 1'b0);
      step(6'b000000, 6'd0, 1'b1);
`ifdef GRAY_SYNC_DECODER_CHECK_EN
      check("int_set_wins", 32'(GrayErr), 1);
`else
      check("int_set_off", 32'(GrayErr), 0);
`endif
      step(6'b000000, 6'd0, 1'b1);

      // stable input, LocalBin moving
      for (int i = 0; i < 20; i++) begin
         lb = 6'($urandom_range(0, 63));
         step(6'b010110, lb, 1'b0);
      end
      check("stable_chg", 32'(Changed), 0);

      // randomized remote walk with occasional glitches and clears
      rb = from_gray(6'b010110);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 1) == 1) rb = rb + 6'd1;
         g = to_gray(rb);
         if ($urandom_range(0, 15) == 0) g = 6'($urandom_range(0, 63));
         lb = 6'($urandom_range(0, 63));
         step(g, lb, ($urandom_range(0, 7) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/gray_sync_decoder.md
# gray_sync_decoder

Receive-side counterpart of the binary-to-Gray pointer encoder in the asynchronous FIFO. Takes a Gray-coded pointer from the other clock domain and passes it through a multi-flop synchronizer. Decodes it to binary and produces a registered distance to the local binary pointer, which the full/empty logic consumes. Also flags Gray-code integrity violations, where consecutive synchronized samples differ in more than one bit.

## Interface
- ADDR_WIDTH, 5: FIFO address width; pointers are ADDR_WIDTH+1 bits, with the MSB used as the wrap bit.
- SYNC_STAGES, 2: number of synchronizer flops; legal range 2–4.
- clk  input  1  local-domain clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset; asserts immediately and is released synchronously by the system.
- GrayIn  input  ADDR_WIDTH+1  Gray pointer from the remote domain; asynchronous to clk.
- LocalBin  input  ADDR_WIDTH+1  local binary pointer, synchronous to clk.
- ErrClr  input  1  synchronous clear of GrayErr.
- BinaryVal  output  ADDR_WIDTH+1  registered binary decode of the synchronized Gray pointer.
- PtrDiff  output  ADDR_WIDTH+1  registered value of (LocalBin − BinaryVal) mod 2^(ADDR_WIDTH+1).
- Changed  output  1  one-cycle pulse when BinaryVal takes a new value.
- GrayErr  output  1  sticky flag for a multi-bit Gray transition.

## Operation
- **Synchronizer:** a shift chain sync[0..SYNC_STAGES-1]; sync[0] <= GrayIn. No logic between the stages.
- **Decode stage:**
  - BinaryVal <= gray2bin(sync[last]), where b[ADDR_WIDTH] = g[ADDR_WIDTH] and b[i] = b[i+1] ^ g[i].
  - PrevGray <= sync[last]. PrevGray is internal and holds the Gray value behind the current BinaryVal.
- **Changed:** registered; equals (sync[last] != PrevGray) and is evaluated at the same edge as the decode.
- **Distance stage:** PtrDiff <= LocalBin − BinaryVal, computed with ADDR_WIDTH+1-bit modular arithmetic. No saturation; the wrap bit is handled naturally by the modular subtraction.
- **Integrity check:**
  - A violation is popcount(sync[last] ^ PrevGray) > 1.
  - On a violation, GrayErr is set at the decode edge.
  - GrayErr holds until ErrClr is sampled high.
  - If a set and a clear occur in the same cycle, the set wins.
- **Wrap-around:** the all-ones binary pointer followed by 0 is a single-bit Gray change and is not an error.
- **Reset:** all sync stages, PrevGray, BinaryVal, PtrDiff, Changed and GrayErr go to 0. Gray 0 decodes to binary 0, so the outputs are consistent from reset.
- **Reset mid-operation:** all outputs clear asynchronously. After release, the first sample that reaches sync[last] is compared against PrevGray = 0.
  - A remote pointer that is non-zero at that point can therefore flag GrayErr.
  - Integrators must reset both domains together, or pulse ErrClr after reset.

## Timing
- Latency, counted in posedges after GrayIn is stable before edge 1:
  - Value in sync[last]: edge SYNC_STAGES.
  - BinaryVal, Changed and GrayErr update: edge SYNC_STAGES+1.
  - PtrDiff update: edge SYNC_STAGES+2.
- For SYNC_STAGES=2: BinaryVal updates at edge 3 and PtrDiff at edge 4.
- PtrDiff uses the LocalBin value sampled at the same edge. There is no extra delay on LocalBin.
- Changed is high for exactly one cycle per distinct new value. Back-to-back remote increments give back-to-back pulses.
- GrayIn must change by at most one bit per remote clock. The block does not filter metastability beyond the sync chain.

## Configuration
- Macro: GRAY_SYNC_DECODER_CHECK_EN.
- **Defined:** the popcount comparator, the GrayErr register and ErrClr handling are compiled in.
- **Undefined:** GrayErr is tied to 0 and ErrClr is ignored. PrevGray is retained because Changed needs it. All other timing is identical.

## Test plan
All scenarios use ADDR_WIDTH=5 and SYNC_STAGES=2.
- **Reset:** assert rst_n=0 mid-cycle with GrayIn=6'b100000 -> all outputs 0 immediately. After release, BinaryVal=63 at edge 3.
- **Decode/latency:** GrayIn 0 -> 6'b000111 -> BinaryVal=5 at edge 3 with Changed high for one cycle. With LocalBin=9, PtrDiff=4 at edge 4.
- **Wrap:** step GrayIn through gray(62)=6'b100001, gray(63)=6'b100000, gray(0)=6'b000000 -> BinaryVal goes 62, 63, 0 and GrayErr stays 0. With LocalBin=3 and BinaryVal=60, PtrDiff=7.
- **Integrity, macro defined:** GrayIn 6'b000000 -> 6'b000011 -> GrayErr=1 and BinaryVal=2 at edge 3. GrayErr holds until ErrClr=1, then is 0 the next cycle. A new violation in the same cycle as ErrClr leaves GrayErr=1.
- **Integrity, macro undefined:** same stimulus -> GrayErr stays 0 and BinaryVal=2.
- **Stable input:** GrayIn held constant for 20 cycles -> Changed stays 0. PtrDiff tracks each LocalBin change with a one-cycle delay.
